// File: rtl/regfile_param.sv
// GPR/SPR register file with byte-enabled write port and an IRQ-ID FIFO whose head loads a fixed SPR.
// Optional `REGFILE_BYPASS_EN forwards same-cycle writes to the read buses.
module regfile_param #(
   parameter int                DATA_W    = 16,
   parameter int                NUM_GPR   = 8,
   parameter int                NUM_SPR   = 8,
   parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(16'hFFFF),
   parameter int                IRQ_SPR   = 2,
   parameter int                IRQ_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_en,
   input  logic                           wr_bank,
   input  logic [7:0]                     wr_addr,
   input  logic [DATA_W/8-1:0]            wr_be,
   input  logic [DATA_W-1:0]              wr_data,
   input  logic [7:0]                     a_op,
   input  logic [7:0]                     b_op,
   input  logic [7:0]                     d_op,
   input  logic [7:0]                     s_op,
   input  logic [7:0]                     e_op,
   output logic [DATA_W-1:0]              a_bus,
   output logic [DATA_W-1:0]              b_bus,
   output logic [DATA_W-1:0]              d_bus,
   output logic [DATA_W-1:0]              s_bus,
   output logic [DATA_W-1:0]              e_bus,
   input  logic                           irq_valid,
   output logic                           irq_ready,
   input  logic [DATA_W-1:0]              irq_id,
   input  logic                           irq_ack,
   output logic                           irq_pending,
   output logic [$clog2(IRQ_DEPTH):0]     irq_count
);

   localparam int LANES = DATA_W / 8;
   localparam int PTR_W = $clog2(IRQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] gpr [NUM_GPR];
   logic [DATA_W-1:0] spr [NUM_SPR];
   logic [DATA_W-1:0] fifo_mem [IRQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              gpr_wr_hit;
   logic              spr_wr_hit;
   logic              irq_push;
   logic              irq_pop;
   logic [DATA_W-1:0] irq_head;

   function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] new_val,
                                                     input logic [LANES-1:0]  be);
      logic [DATA_W-1:0] r;
      r = old_val;
      for (int l = 0; l < LANES; l++) begin
         if (be[l]) r[8*l +: 8] = new_val[8*l +: 8];
      end
      return r;
   endfunction

   // Hit signals already exclude out-of-range indices, so a bypass match never forwards to a 0-reading port.
   assign gpr_wr_hit = wr_en && !wr_bank && (32'(wr_addr) < NUM_GPR);
   assign spr_wr_hit = wr_en &&  wr_bank && (32'(wr_addr) < NUM_SPR);

   function automatic logic [DATA_W-1:0] read_gpr(input logic [7:0] idx);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_GPR; i++) begin
         if (idx == 8'(i)) r = gpr[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (gpr_wr_hit && (wr_addr == idx)) r = merge_lanes(r, wr_data, wr_be);
`endif
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] read_spr(input logic [7:0] idx);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_SPR; i++) begin
         if (idx == 8'(i)) r = spr[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (spr_wr_hit && (wr_addr == idx)) r = merge_lanes(r, wr_data, wr_be);
`endif
      return r;
   endfunction

   assign a_bus = read_gpr(a_op);
   assign b_bus = read_gpr(b_op);
   assign d_bus = read_gpr(d_op);
   assign s_bus = read_spr(s_op);
   assign e_bus = read_spr(e_op);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_GPR; i++) begin
            if (gpr_wr_hit && (wr_addr == 8'(i))) gpr[i] <= merge_lanes(gpr[i], wr_data, wr_be);
         end
      end
   end

   // A dequeue into IRQ_SPR overrides a core write to the same SPR on every lane.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SPR; i++) spr[i] <= (i == 0) ? RESET_VEC : '0;
      end else begin
         for (int i = 0; i < NUM_SPR; i++) begin
            if (irq_pop && (i == IRQ_SPR)) spr[i] <= irq_head;
            else if (spr_wr_hit && (wr_addr == 8'(i))) spr[i] <= merge_lanes(spr[i], wr_data, wr_be);
         end
      end
   end

   assign irq_ready   = (count_q != CNT_W'(IRQ_DEPTH));
   assign irq_pending = (count_q != '0);
   assign irq_count   = count_q;
   assign irq_push    = irq_valid && irq_ready;
   assign irq_pop     = irq_ack && irq_pending;
   assign irq_head    = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (irq_push) fifo_mem[wr_ptr] <= irq_id;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (irq_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (irq_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({irq_push, irq_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
